// File: rtl/sipo_deserializer.sv
// Purpose : serial-in/parallel-out deserializer; collects FRAME_LEN sampled bits into an OUTPUT_WIDTH word.
// Latency : data/data_valid update on the edge that samples the last bit of a frame (registered, visible next cycle).
// Backpressure: none; shift_en gates sampling, sync restarts the frame, data_valid is a one-cycle pulse.
//
// Ports:
//   clk        - single clock, all state changes on rising edge
//   rst_n      - asynchronous active-low reset
//   shift_en   - sample serial_in on this edge
//   serial_in  - serial data bit
//   sync       - frame restart, discards any partial frame
//   data       - last completed word (held between completions)
//   data_valid - one-cycle pulse, data just updated
//   busy       - registered, high while a frame is partially received
//   parity_err - (SIPO_PARITY_EN only) XOR of the data bits and the trailing even-parity bit
//
// Optional feature macro: SIPO_PARITY_EN adds one even-parity bit per frame and the parity_err output.

module sipo_deserializer #(
    parameter int   OUTPUT_WIDTH = 8,
    parameter int   MSB_FIRST    = 1,
    parameter logic VALUE_PULL   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    shift_en,
    input  logic                    serial_in,
    input  logic                    sync,
    output logic [OUTPUT_WIDTH-1:0] data,
    output logic                    data_valid,
`ifdef SIPO_PARITY_EN
    output logic                    parity_err,
`endif
    output logic                    busy
);

`ifdef SIPO_PARITY_EN
    localparam int FRAME_LEN = OUTPUT_WIDTH + 1;
`else
    localparam int FRAME_LEN = OUTPUT_WIDTH;
`endif
    localparam int                    CNT_W    = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic [OUTPUT_WIDTH-1:0] FILL   = {OUTPUT_WIDTH{VALUE_PULL}};

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [OUTPUT_WIDTH-1:0]   sr_q, sr_d;
    logic [OUTPUT_WIDTH-1:0]   data_q, data_d;
    logic                      data_valid_q, data_valid_d;
`ifdef SIPO_PARITY_EN
    logic                      parity_err_q, parity_err_d;
`endif

    logic [OUTPUT_WIDTH-1:0]   base_sr;
    logic [OUTPUT_WIDTH-1:0]   shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sr_q         <= FILL;
            data_q       <= FILL;
            data_valid_q <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
`ifdef SIPO_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        sr_d         = sr_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
`ifdef SIPO_PARITY_EN
        parity_err_d = parity_err_q;
`endif

        // A sync on a sampling edge starts the new frame from a clean register,
        // so the sampled bit is shifted into the fill pattern rather than the stale frame.
        base_sr = sync ? FILL : sr_q;
        if (MSB_FIRST != 0) begin
            shifted = {base_sr[OUTPUT_WIDTH-2:0], serial_in};
        end else begin
            shifted = {serial_in, base_sr[OUTPUT_WIDTH-1:1]};
        end

        if (shift_en) begin
            if (sync) begin
                sr_d  = shifted;
                cnt_d = CNT_W'(1);
            end else if (cnt_q == LAST_CNT) begin
                data_valid_d = 1'b1;
                cnt_d        = '0;
                sr_d         = FILL;
`ifdef SIPO_PARITY_EN
                // Last bit is the parity bit: the data bits are already complete in sr_q.
                data_d       = sr_q;
                parity_err_d = (^sr_q) ^ serial_in;
`else
                data_d       = shifted;
`endif
            end else begin
                sr_d  = shifted;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (sync) begin
            cnt_d = '0;
            sr_d  = FILL;
        end

        state_d = (cnt_d != '0) ? RECV : IDLE;
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign busy       = (state_q == RECV);
`ifdef SIPO_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Purpose : self-checking bench for sipo_deserializer, MSB-first and LSB-first instances side by side.
// Latency : checks outputs #1 after each sampling edge; scoreboard pops on every data_valid pulse.
// Backpressure: none; stimulus drives shift_en/serial_in/sync directly, every wait is a fixed cycle count.

module tb_sipo_deserializer;

`ifdef SIPO_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       shift_en;
    logic       serial_in;
    logic       sync;
    logic [7:0] data_m, data_l;
    logic       dv_m, dv_l, busy_m, busy_l;
`ifdef SIPO_PARITY_EN
    logic       perr_m, perr_l;
    logic       exp_p_q[$];
    logic       e_p;
`endif

    int         vectors     = 0;
    int         miscompares = 0;
    int         pulses_m    = 0;
    int         pulses_l    = 0;
    logic [7:0] exp_m_q[$];
    logic [7:0] exp_l_q[$];
    logic [7:0] e_m, e_l;

    always #5 clk = ~clk;

    sipo_deserializer #(.OUTPUT_WIDTH(8), .MSB_FIRST(1), .VALUE_PULL(1'b0)) dut_m (
        .clk(clk), .rst_n(rst_n), .shift_en(shift_en), .serial_in(serial_in), .sync(sync),
        .data(data_m), .data_valid(dv_m),
`ifdef SIPO_PARITY_EN
        .parity_err(perr_m),
`endif
        .busy(busy_m)
    );

    sipo_deserializer #(.OUTPUT_WIDTH(8), .MSB_FIRST(0), .VALUE_PULL(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .shift_en(shift_en), .serial_in(serial_in), .sync(sync),
        .data(data_l), .data_valid(dv_l),
`ifdef SIPO_PARITY_EN
        .parity_err(perr_l),
`endif
        .busy(busy_l)
    );

    // Scoreboard: every data_valid pulse must match the next expected word.
    always @(negedge clk) begin
        if (dv_m) begin
            pulses_m++;
            vectors++;
            if (exp_m_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_msb: unexpected pulse data=%h, no word expected", data_m);
            end else begin
                e_m = exp_m_q.pop_front();
                if (data_m !== e_m) begin
                    miscompares++;
                    $display("FAIL sb_msb: data=%h expected %h", data_m, e_m);
                end
            end
`ifdef SIPO_PARITY_EN
            if (exp_p_q.size() != 0) begin
                e_p = exp_p_q.pop_front();
                vectors++;
                if (perr_m !== e_p) begin
                    miscompares++;
                    $display("FAIL sb_parity: parity_err=%b expected %b", perr_m, e_p);
                end
            end
`endif
        end
        if (dv_l) begin
            pulses_l++;
            vectors++;
            if (exp_l_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_lsb: unexpected pulse data=%h, no word expected", data_l);
            end else begin
                e_l = exp_l_q.pop_front();
                if (data_l !== e_l) begin
                    miscompares++;
                    $display("FAIL sb_lsb: data=%h expected %h", data_l, e_l);
                end
            end
        end
    end

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic step(input logic sen, input logic sin, input logic syn);
        shift_en  = sen;
        serial_in = sin;
        sync      = syn;
        @(posedge clk);
        #1;
        shift_en  = 1'b0;
        sync      = 1'b0;
    endtask

    // Word sent MSB first: the MSB-first instance sees w, the LSB-first one sees it reversed.
    task automatic push_exp(input logic [7:0] w);
        exp_m_q.push_back(w);
        exp_l_q.push_back(rev8(w));
`ifdef SIPO_PARITY_EN
        exp_p_q.push_back(1'b0);
`endif
    endtask

    // Sends w[hi] down to w[lo]; closing the frame (lo == 0) appends correct parity when enabled.
    task automatic send_bits(input logic [7:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) step(1'b1, w[i], 1'b0);
`ifdef SIPO_PARITY_EN
        if (lo == 0) step(1'b1, ^w, 1'b0);
`endif
    endtask

    task automatic send_word(input logic [7:0] w);
        push_exp(w);
        send_bits(w, 7, 0);
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        shift_en  = 1'b0;
        serial_in = 1'b0;
        sync      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({data_m, dv_m, busy_m} !== 10'h000) begin
            miscompares++;
            $display("FAIL reset_msb: data=%h dv=%b busy=%b expected 00/0/0", data_m, dv_m, busy_m);
        end
        vectors++;
        if ({data_l, dv_l, busy_l} !== 10'h000) begin
            miscompares++;
            $display("FAIL reset_lsb: data=%h dv=%b busy=%b expected 00/0/0", data_l, dv_l, busy_l);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        vectors++;
        if ({data_m, dv_m, busy_m} !== 10'h000) begin
            miscompares++;
            $display("FAIL reset_release: data=%h dv=%b busy=%b expected 00/0/0", data_m, dv_m, busy_m);
        end
    endtask

    task automatic test_msb_basic;
        int p0;
        p0 = pulses_m;
        push_exp(8'hD8);
        send_bits(8'hD8, 7, 1);
        vectors++;
        if (busy_m !== 1'b1) begin
            miscompares++;
            $display("FAIL msb_busy_mid: busy=%b expected 1", busy_m);
        end
        send_bits(8'hD8, 0, 0);
        vectors++;
        if ({data_m, dv_m, busy_m} !== {8'hD8, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL msb_done: data=%h dv=%b busy=%b expected d8/1/0", data_m, dv_m, busy_m);
        end
        step(1'b0, 1'b0, 1'b0);
        vectors++;
        if ({data_m, dv_m} !== {8'hD8, 1'b0}) begin
            miscompares++;
            $display("FAIL msb_pulse_width: data=%h dv=%b expected d8/0", data_m, dv_m);
        end
        vectors++;
        if (pulses_m - p0 != 1) begin
            miscompares++;
            $display("FAIL msb_pulse_count: %0d pulses expected 1", pulses_m - p0);
        end
    endtask

    task automatic test_lsb;
        int p0;
        p0 = pulses_l;
        // Stream 0,0,0,1,1,0,1,1 is 8'h1B sent MSB first.
        send_word(8'h1B);
        vectors++;
        if ({data_l, dv_l, busy_l} !== {8'hD8, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL lsb_done: data=%h dv=%b busy=%b expected d8/1/0", data_l, dv_l, busy_l);
        end
        step(1'b0, 1'b0, 1'b0);
        vectors++;
        if (pulses_l - p0 != 1) begin
            miscompares++;
            $display("FAIL lsb_pulse_count: %0d pulses expected 1", pulses_l - p0);
        end
    endtask

    task automatic test_gap;
        int p0;
        p0 = pulses_m;
        push_exp(8'hD8);
        send_bits(8'hD8, 7, 4);
        for (int g = 0; g < 3; g++) begin
            step(1'b0, g[0], 1'b0);
            vectors++;
            if ({busy_m, dv_m} !== 2'b10) begin
                miscompares++;
                $display("FAIL gap_busy: cycle %0d busy=%b dv=%b expected 1/0", g, busy_m, dv_m);
            end
        end
        send_bits(8'hD8, 3, 0);
        vectors++;
        if ({data_m, dv_m, busy_m} !== {8'hD8, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL gap_done: data=%h dv=%b busy=%b expected d8/1/0", data_m, dv_m, busy_m);
        end
        step(1'b0, 1'b0, 1'b0);
        vectors++;
        if (pulses_m - p0 != 1) begin
            miscompares++;
            $display("FAIL gap_pulse_count: %0d pulses expected 1", pulses_m - p0);
        end
    endtask

    task automatic test_sync_abort;
        int         p0;
        logic [7:0] junk;
        p0   = pulses_m;
        junk = 8'h5B;
        for (int i = 7; i >= 3; i--) step(1'b1, junk[i], 1'b0);
        step(1'b0, 1'b1, 1'b1);
        vectors++;
        if ({busy_m, dv_m, data_m} !== {1'b0, 1'b0, 8'hD8}) begin
            miscompares++;
            $display("FAIL sync_abort: busy=%b dv=%b data=%h expected 0/0/d8", busy_m, dv_m, data_m);
        end
        send_word(8'hA5);
        vectors++;
        if ({data_m, dv_m} !== {8'hA5, 1'b1}) begin
            miscompares++;
            $display("FAIL sync_abort_word: data=%h dv=%b expected a5/1", data_m, dv_m);
        end
        step(1'b0, 1'b0, 1'b0);
        vectors++;
        if (pulses_m - p0 != 1) begin
            miscompares++;
            $display("FAIL sync_abort_pulses: %0d pulses expected 1", pulses_m - p0);
        end
    endtask

    task automatic test_sync_shift;
        int p0;
        p0 = pulses_m;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        push_exp(8'h69);
        // Sync on a sampling edge: this bit becomes bit 1 of the new frame.
        step(1'b1, 1'b0, 1'b1);
        vectors++;
        if (busy_m !== 1'b1) begin
            miscompares++;
            $display("FAIL sync_shift_busy: busy=%b expected 1", busy_m);
        end
        send_bits(8'h69, 6, 0);
        vectors++;
        if ({data_m, dv_m, data_l} !== {8'h69, 1'b1, rev8(8'h69)}) begin
            miscompares++;
            $display("FAIL sync_shift_word: data=%h dv=%b lsb=%h expected 69/1/96", data_m, dv_m, data_l);
        end
        step(1'b0, 1'b0, 1'b0);
        vectors++;
        if (pulses_m - p0 != 1) begin
            miscompares++;
            $display("FAIL sync_shift_pulses: %0d pulses expected 1", pulses_m - p0);
        end
    endtask

    task automatic test_reset_midframe;
        for (int i = 0; i < 6; i++) step(1'b1, i[0], 1'b0);
        rst_n = 1'b0;
        #2;
        vectors++;
        if ({data_m, dv_m, busy_m} !== 10'h000) begin
            miscompares++;
            $display("FAIL rst_mid: data=%h dv=%b busy=%b expected 00/0/0", data_m, dv_m, busy_m);
        end
        step(1'b1, 1'b1, 1'b0);
        vectors++;
        if ({data_l, dv_l, busy_l, busy_m} !== 11'h000) begin
            miscompares++;
            $display("FAIL rst_hold: lsb data=%h dv=%b busy=%b msb busy=%b expected 00/0/0/0",
                     data_l, dv_l, busy_l, busy_m);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_word(8'h3C);
        vectors++;
        if ({data_m, dv_m, busy_m} !== {8'h3C, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_mid_word: data=%h dv=%b busy=%b expected 3c/1/0", data_m, dv_m, busy_m);
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [7:0] words[4];
        logic       b;
        int         p0;
        p0 = pulses_m;
        for (int k = 0; k < 4; k++) begin
            words[k] = 8'($urandom_range(0, 255));
            push_exp(words[k]);
        end
        for (int k = 0; k < 4; k++) begin
            for (int i = FL - 1; i >= 0; i--) begin
                b = (i >= FL - 8) ? words[k][i-(FL-8)] : ^words[k];
                step(1'b1, b, 1'b0);
                vectors++;
                if (dv_m !== (i == 0)) begin
                    miscompares++;
                    $display("FAIL b2b_pulse: word %0d bit %0d dv=%b expected %b", k, i, dv_m, i == 0);
                end
            end
        end
        step(1'b0, 1'b0, 1'b0);
        vectors++;
        if (pulses_m - p0 != 4) begin
            miscompares++;
            $display("FAIL b2b_pulse_count: %0d pulses expected 4", pulses_m - p0);
        end
        // Idle edges with noisy serial_in must not disturb the held word.
        for (int j = 0; j < 4; j++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        vectors++;
        if ({data_m, dv_m, busy_m} !== {words[3], 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL hold: data=%h dv=%b busy=%b expected %h/0/0", data_m, dv_m, busy_m, words[3]);
        end
    endtask

`ifdef SIPO_PARITY_EN
    task automatic test_parity;
        push_exp(8'hD8);
        send_bits(8'hD8, 7, 0);
        vectors++;
        if ({perr_m, dv_m} !== 2'b01) begin
            miscompares++;
            $display("FAIL parity_good: parity_err=%b dv=%b expected 0/1", perr_m, dv_m);
        end
        exp_m_q.push_back(8'hD8);
        exp_l_q.push_back(rev8(8'hD8));
        exp_p_q.push_back(1'b1);
        send_bits(8'hD8, 7, 1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        vectors++;
        if ({perr_m, dv_m} !== 2'b11) begin
            miscompares++;
            $display("FAIL parity_bad: parity_err=%b dv=%b expected 1/1", perr_m, dv_m);
        end
        step(1'b0, 1'b0, 1'b0);
        vectors++;
        if (perr_m !== 1'b1) begin
            miscompares++;
            $display("FAIL parity_hold: parity_err=%b expected 1", perr_m);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_msb_basic();
        test_lsb();
        test_gap();
        test_sync_abort();
        test_sync_shift();
        test_reset_midframe();
        test_back_to_back();
`ifdef SIPO_PARITY_EN
        test_parity();
`endif
        step(1'b0, 1'b0, 1'b0);
        vectors++;
        if (exp_m_q.size() + exp_l_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: %0d msb and %0d lsb words never produced", exp_m_q.size(), exp_l_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
